// File: rtl/serial_adder.sv
// Bit-serial, LSB-first ripple adder built from one full-adder cell and a carry flip-flop.
// Each add takes WIDTH RUN cycles plus one DONE cycle. Results are held until the next completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OV
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one sum bit per edge, exactly WIDTH edges
  // DONE  | result registers just updated, done pulse, may reload
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [CW-1:0]    count;
  logic             carry;
  logic             sum_bit, carry_nxt, last_bit, load;

  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit  = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // busy/done decode from the state register only, so no input reaches an output combinationally
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      count <= '0;
      carry <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      OV    <= 1'b0;
    end else if (load) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      count <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {sum_bit, s_sr[WIDTH-1:1]};
      carry <= carry_nxt;
      count <= count + 1'b1;
      if (last_bit) begin
        S    <= {sum_bit, s_sr[WIDTH-1:1]};
        Cout <= carry_nxt;
        // carry into the MSB xor carry out of the MSB
        OV   <= carry ^ carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 2 and 16: directed cases on the 8-bit unit,
// then random operands checked against an arithmetic reference model on every instance.
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  start_d;
  logic [2:0]  cin_d;
  logic [15:0] a_d [3];
  logic [15:0] b_d [3];

  wire  [2:0]  busy_v, done_v, cout_v, ov_v;
  wire  [7:0]  s0;
  wire  [1:0]  s1;
  wire  [15:0] s2;
  logic [15:0] s_v [3];

  assign s_v[0] = {8'h00, s0};
  assign s_v[1] = {14'h0000, s1};
  assign s_v[2] = s2;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_d[0]), .A(a_d[0][7:0]), .B(b_d[0][7:0]), .Cin(cin_d[0]),
    .busy(busy_v[0]), .done(done_v[0]), .S(s0), .Cout(cout_v[0]), .OV(ov_v[0]));

  serial_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start_d[1]), .A(a_d[1][1:0]), .B(b_d[1][1:0]), .Cin(cin_d[1]),
    .busy(busy_v[1]), .done(done_v[1]), .S(s1), .Cout(cout_v[1]), .OV(ov_v[1]));

  serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_d[2]), .A(a_d[2]), .B(b_d[2]), .Cin(cin_d[2]),
    .busy(busy_v[2]), .done(done_v[2]), .S(s2), .Cout(cout_v[2]), .OV(ov_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q [3][$];
  int   checks = 0;
  int   errors = 0;
  int   tmo_req = 0;
  int   tmo_seen = 0;
  logic exp_zero = 1'b0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;
  logic rst_edge;

  int          busy_len [3];
  logic        prev_done [3];
  logic [17:0] prev_out [3];

  function automatic int wid(int i);
    if (i == 0) return 8;
    else if (i == 1) return 2;
    else return 16;
  endfunction

  // Reference: plain integer addition, sign rule for overflow.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic c);
    exp_t   e;
    longint full, m;
    full   = longint'(a) + longint'(b) + longint'(c);
    m      = longint'(1) << w;
    e.s    = 16'(full % m);
    e.cout = (full >= m);
    e.ov   = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  always @(posedge clk) rst_edge <= rst;

  task automatic mon(int i);
    exp_t        e;
    logic [17:0] cur;
    cur = {s_v[i], cout_v[i], ov_v[i]};
    checks++;
    if (busy_v[i] === 1'b1 && done_v[i] === 1'b1) begin
      errors++;
      $display("FAIL busy_done_excl w%0d: busy=%b done=%b, required not both 1", wid(i), busy_v[i], done_v[i]);
    end
    if (exp_zero) begin
      checks++;
      if ({busy_v[i], done_v[i], cout_v[i], ov_v[i]} !== 4'b0000 || s_v[i] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_vals w%0d: busy=%b done=%b S=%h Cout=%b OV=%b, required all 0",
                 wid(i), busy_v[i], done_v[i], s_v[i], cout_v[i], ov_v[i]);
      end
    end
    if (done_v[i] === 1'b1) begin
      checks++;
      if (prev_done[i] === 1'b1) begin
        errors++;
        $display("FAIL done_width w%0d: done high 2 cycles in a row, required 1", wid(i));
      end
      checks++;
      if (busy_len[i] != wid(i)) begin
        errors++;
        $display("FAIL busy_to_done w%0d: got %0d busy cycles, required %0d", wid(i), busy_len[i], wid(i));
      end
      checks++;
      if (q[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_done w%0d: done with no outstanding operation, S=%h", wid(i), s_v[i]);
      end else begin
        e = q[i].pop_front();
        if (cur !== {e.s, e.cout, e.ov}) begin
          errors++;
          $display("FAIL result w%0d: got S=%h Cout=%b OV=%b, required S=%h Cout=%b OV=%b",
                   wid(i), s_v[i], cout_v[i], ov_v[i], e.s, e.cout, e.ov);
        end
      end
      busy_len[i] = 0;
    end else begin
      if (busy_v[i] === 1'b1) busy_len[i]++;
      else busy_len[i] = 0;
      if (rst_edge === 1'b0) begin
        checks++;
        if (cur !== prev_out[i]) begin
          errors++;
          $display("FAIL hold w%0d: outputs %h changed without done, required %h", wid(i), cur, prev_out[i]);
        end
      end
    end
    prev_done[i] = done_v[i];
    prev_out[i]  = cur;
  endtask

  always @(negedge clk) begin
    if (tmo_req != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d waits for done expired, required 0", tmo_req - tmo_seen);
      tmo_seen = tmo_req;
    end
    for (int i = 0; i < 3; i++) mon(i);
    if (final_req && !final_done) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i].size() != 0) begin
          errors++;
          $display("FAIL drain w%0d: %0d results never delivered, required 0", wid(i), q[i].size());
        end
      end
      final_done = 1'b1;
    end
  end

  // Caller is positioned at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(int i, logic [15:0] a, logic [15:0] b, logic c);
    a_d[i] = a; b_d[i] = b; cin_d[i] = c; start_d[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d[i] = 1'b0;
    a_d[i] = 16'($urandom); b_d[i] = 16'($urandom); cin_d[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(int i, int bound);
    int n = 0;
    while (done_v[i] !== 1'b1) begin
      if (n >= bound) begin
        tmo_req++;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  function automatic exp_t mk(logic [15:0] s, logic c, logic o);
    exp_t e;
    e.s = s; e.cout = c; e.ov = o;
    return e;
  endfunction

  task automatic rand_run(int i, int n);
    int          w;
    logic [15:0] msk, a, b;
    logic        c;
    w   = wid(i);
    msk = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    for (int k = 0; k < n; k++) begin
      a = 16'($urandom) & msk;
      b = 16'($urandom) & msk;
      c = 1'($urandom_range(0, 1));
      q[i].push_back(model(w, a, b, c));
      issue(i, a, b, c);
      if ($urandom_range(0, 3) == 0) begin
        start_d[i] = 1'b1;
        @(negedge clk);
        start_d[i] = 1'b0;
      end
      wait_done(i, w + 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_len[i] = 0; prev_done[i] = 1'b0; prev_out[i] = '0;
      a_d[i] = 16'h003C; b_d[i] = 16'h005A;
    end
    cin_d   = 3'b000;
    start_d = 3'b111;
    rst     = 1'b1;

    // reset held 3 edges with start asserted
    @(posedge clk); #1 exp_zero = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0; start_d = 3'b000;
    @(posedge clk); #1 exp_zero = 1'b0;

    @(negedge clk);
    q[0].push_back(mk(16'h0096, 1'b0, 1'b1));
    issue(0, 16'h3C, 16'h5A, 1'b0);
    wait_done(0, 11);

    @(negedge clk);
    q[0].push_back(mk(16'h0000, 1'b1, 1'b0));
    issue(0, 16'hFF, 16'h01, 1'b0);
    wait_done(0, 11);
    q[0].push_back(mk(16'h0080, 1'b0, 1'b1));
    issue(0, 16'h7F, 16'h00, 1'b1);
    wait_done(0, 11);

    // start during RUN is ignored; start during DONE reloads immediately
    @(negedge clk);
    q[0].push_back(mk(16'h0030, 1'b0, 1'b0));
    issue(0, 16'h10, 16'h20, 1'b0);
    a_d[0] = 16'h01; b_d[0] = 16'h01; start_d[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_d[0] = 1'b0;
    wait_done(0, 11);
    q[0].push_back(mk(16'h0000, 1'b1, 1'b1));
    issue(0, 16'h80, 16'h80, 1'b0);
    wait_done(0, 11);

    // reset at the 4th RUN edge aborts with no done pulse
    @(negedge clk);
    a_d[0] = 16'h11; b_d[0] = 16'h22; cin_d[0] = 1'b0; start_d[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 exp_zero = 1'b1; rst = 1'b0;
    @(posedge clk); #1 exp_zero = 1'b0;
    repeat (12) @(negedge clk);
    q[0].push_back(mk(16'h0008, 1'b0, 1'b0));
    issue(0, 16'h05, 16'h03, 1'b0);
    wait_done(0, 11);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_run(i, 1000);
    end

    @(negedge clk);
    final_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
